// File: rtl/logic_latch_pkg.sv
// Shared constants and the capture rule for the TTM4 373/374 latch bank.
// Channel MODE selects transparent-latch or rising-edge-register behaviour.
package logic_latch_pkg;

  localparam logic MODE_LATCH = 1'b0;
  localparam logic MODE_EDGE  = 1'b1;

  localparam int DEFAULT_WIDTH       = 8;
  localparam int DEFAULT_CHANNELS    = 4;
  localparam int DEFAULT_SYNC_STAGES = 2;

  // A 373 stores on every cycle LE is high; a 374 stores only on the cycle LE first rises.
  function automatic logic capture_now(input logic mode, input logic le_s, input logic le_p);
    return (mode == MODE_EDGE) ? (le_s & ~le_p) : le_s;
  endfunction

endpackage

// File: rtl/logic_latch_channel.sv
// One WIDTH-bit latch/register channel: pin synchronisers, LE edge detect,
// storage register and change pulse.
module logic_latch_channel
  import logic_latch_pkg::*;
#(
  parameter int WIDTH       = DEFAULT_WIDTH,
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  input  logic             le,
  input  logic             noe,
  input  logic             mode,
  output logic [WIDTH-1:0] q,
  output logic             qoe,
  output logic             chg
);

  logic [WIDTH-1:0]       d_sync [SYNC_STAGES];
  logic [SYNC_STAGES-1:0] le_sync;
  logic [SYNC_STAGES-1:0] noe_sync;

  logic [WIDTH-1:0] d_s;
  logic             le_s;
  logic             noe_s;
  logic             le_p;
  logic             write_en;
  logic [WIDTH-1:0] store;

  // D, LE and nOE share one chain depth so D stays aligned with its LE edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        d_sync[i] <= '0;
      end
      le_sync  <= '0;
      noe_sync <= '1;
    end else begin
      d_sync[0] <= d;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        d_sync[i] <= d_sync[i-1];
      end
      le_sync  <= {le_sync[SYNC_STAGES-2:0], le};
      noe_sync <= {noe_sync[SYNC_STAGES-2:0], noe};
    end
  end

  assign d_s      = d_sync[SYNC_STAGES-1];
  assign le_s     = le_sync[SYNC_STAGES-1];
  assign noe_s    = noe_sync[SYNC_STAGES-1];
  assign write_en = capture_now(mode, le_s, le_p);

  // le_p tracks LE in both modes, so entering edge mode with LE already high never captures.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      le_p  <= 1'b0;
      store <= '0;
      chg   <= 1'b0;
    end else begin
      le_p <= le_s;
      chg  <= write_en && (d_s != store);
      if (write_en) begin
        store <= d_s;
      end
    end
  end

  assign qoe = ~noe_s;
  assign q   = qoe ? store : '0;

endmodule

// File: rtl/logic_latch_bank.sv
// Bank of independent 74HC373/374-style channels; Q is a plain vector plus a
// per-channel drive enable, leaving the tri-state buffers to the pad ring.
module logic_latch_bank
  import logic_latch_pkg::*;
#(
  parameter int WIDTH       = DEFAULT_WIDTH,
  parameter int CHANNELS    = DEFAULT_CHANNELS,
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic                      CLK,
  input  logic                      nRST,
  input  logic [CHANNELS*WIDTH-1:0] D,
  input  logic [CHANNELS-1:0]       LE,
  input  logic [CHANNELS-1:0]       nOE,
  input  logic [CHANNELS-1:0]       MODE,
  output logic [CHANNELS*WIDTH-1:0] Q,
  output logic [CHANNELS-1:0]       QOE,
  output logic [CHANNELS-1:0]       CHG
);

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic_latch_channel #(
      .WIDTH      (WIDTH),
      .SYNC_STAGES(SYNC_STAGES)
    ) u_ch (
      .clk  (CLK),
      .rst_n(nRST),
      .d    (D[c*WIDTH +: WIDTH]),
      .le   (LE[c]),
      .noe  (nOE[c]),
      .mode (MODE[c]),
      .q    (Q[c*WIDTH +: WIDTH]),
      .qoe  (QOE[c]),
      .chg  (CHG[c])
    );
  end

endmodule

// File: tb/tb_logic_latch_bank.sv
// Bench for logic_latch_bank: directed scenarios with literal expectations,
// then random pin traffic compared every cycle against a sample-history model.
module tb_logic_latch_bank;

  localparam int W   = 8;
  localparam int CH  = 4;
  localparam int S   = 2;
  localparam int W2  = 4;
  localparam int CH2 = 2;
  localparam int S2  = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b1;

  logic [CH*W-1:0] d;
  logic [CH-1:0]   le, noe, mode;
  logic [CH*W-1:0] q;
  logic [CH-1:0]   qoe, chg;

  logic [CH2*W2-1:0] d_b;
  logic [CH2-1:0]    le_b, noe_b, mode_b;
  logic [CH2*W2-1:0] q_b;
  logic [CH2-1:0]    qoe_b, chg_b;

  int n_checks = 0;
  int n_fail   = 0;

  logic_latch_bank #(.WIDTH(W), .CHANNELS(CH), .SYNC_STAGES(S)) dut (
    .CLK(clk), .nRST(rst_n), .D(d), .LE(le), .nOE(noe), .MODE(mode),
    .Q(q), .QOE(qoe), .CHG(chg)
  );

  logic_latch_bank #(.WIDTH(W2), .CHANNELS(CH2), .SYNC_STAGES(S2)) dut_b (
    .CLK(clk), .nRST(rst_n), .D(d_b), .LE(le_b), .nOE(noe_b), .MODE(mode_b),
    .Q(q_b), .QOE(qoe_b), .CHG(chg_b)
  );

  // Reference model: a log of what the pins looked like at each rising edge.
  typedef struct packed {
    logic [CH*W-1:0] d;
    logic [CH-1:0]   le;
    logic [CH-1:0]   noe;
  } sample_t;

  sample_t    hist[$];
  logic [W-1:0] exp_store [CH];
  logic         exp_chg   [CH];
  logic         exp_qoe   [CH];
  bit           model_live = 1'b0;

  task automatic model_reset();
    sample_t r;
    r.d   = '0;
    r.le  = '0;
    r.noe = '1;
    hist.delete();
    for (int i = 0; i < S + 1; i++) hist.push_back(r);
    for (int c = 0; c < CH; c++) begin
      exp_store[c] = '0;
      exp_chg[c]   = 1'b0;
      exp_qoe[c]   = 1'b0;
    end
  endtask

  // An edge acts on the pins seen S edges ago; "previous LE" is one edge older still.
  always @(posedge clk) begin
    sample_t seen, older, now_s;
    logic    wr;
    if (!rst_n) begin
      model_reset();
    end else begin
      seen  = hist[hist.size() - S];
      older = hist[hist.size() - S - 1];
      for (int c = 0; c < CH; c++) begin
        wr = mode[c] ? (seen.le[c] && !older.le[c]) : seen.le[c];
        exp_chg[c] = wr && (seen.d[c*W +: W] != exp_store[c]);
        if (wr) exp_store[c] = seen.d[c*W +: W];
      end
      now_s.d   = d;
      now_s.le  = le;
      now_s.noe = noe;
      hist.push_back(now_s);
      void'(hist.pop_front());
      for (int c = 0; c < CH; c++) exp_qoe[c] = !hist[hist.size() - S].noe[c];
    end
    model_live = 1'b1;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (model_live && rst_n) begin
      for (int c = 0; c < CH; c++) begin
        checkOutput($sformatf("model ch%0d Q", c), 32'(q[c*W +: W]),
                    exp_qoe[c] ? 32'(exp_store[c]) : 32'h0);
        checkOutput($sformatf("model ch%0d QOE", c), 32'(qoe[c]), 32'(exp_qoe[c]));
        checkOutput($sformatf("model ch%0d CHG", c), 32'(chg[c]), 32'(exp_chg[c]));
      end
    end
  end

  task automatic applyStimulus(input int c, input logic [W-1:0] dv, input logic lev,
                               input logic noev, input logic modev);
    d[c*W +: W] = dv;
    le[c]       = lev;
    noe[c]      = noev;
    mode[c]     = modev;
  endtask

  function automatic logic [31:0] qch(input int c);
    return 32'(q[c*W +: W]);
  endfunction

  initial begin
    model_reset();
    d      = {CH{8'hFF}};
    le     = '1;
    noe    = '0;
    mode   = '0;
    d_b    = '0;
    le_b   = '0;
    noe_b  = '0;
    mode_b = '0;
    #2 rst_n = 1'b0;

    // Reset holds everything quiet even with LE high and outputs enabled
    repeat (3) begin
      @(negedge clk);
      checkOutput("reset Q", q, 32'h0);
      checkOutput("reset QOE", 32'(qoe), 32'h0);
      checkOutput("reset CHG", 32'(chg), 32'h0);
    end
    #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("release ch0 Q before capture", qch(0), 32'h0);
    @(negedge clk);
    checkOutput("release ch0 Q after 3 edges", qch(0), 32'hFF);
    checkOutput("release ch0 CHG pulse", 32'(chg[0]), 32'h1);
    @(negedge clk);
    checkOutput("release ch0 CHG single", 32'(chg[0]), 32'h0);

    // Mode 0 transparent streaming
    #1 applyStimulus(0, 8'h12, 1'b1, 1'b0, 1'b0);
    @(negedge clk); #1 applyStimulus(0, 8'h34, 1'b1, 1'b0, 1'b0);
    @(negedge clk); #1 applyStimulus(0, 8'h56, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("m0 Q 12", qch(0), 32'h12);
    checkOutput("m0 CHG 12", 32'(chg[0]), 32'h1);
    @(negedge clk);
    checkOutput("m0 Q 34", qch(0), 32'h34);
    checkOutput("m0 CHG 34", 32'(chg[0]), 32'h1);
    @(negedge clk);
    checkOutput("m0 Q 56", qch(0), 32'h56);
    checkOutput("m0 CHG 56", 32'(chg[0]), 32'h1);
    #1 applyStimulus(0, 8'h56, 1'b0, 1'b0, 1'b0);
    @(negedge clk); #1 applyStimulus(0, 8'h99, 1'b0, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    checkOutput("m0 hold Q", qch(0), 32'h56);
    checkOutput("m0 hold CHG", 32'(chg[0]), 32'h0);

    // Mode 1 rising-edge register
    #1 applyStimulus(1, 8'hFF, 1'b0, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    #1 applyStimulus(1, 8'hA5, 1'b1, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    checkOutput("m1 Q A5", qch(1), 32'hA5);
    checkOutput("m1 CHG A5", 32'(chg[1]), 32'h1);
    #1 applyStimulus(1, 8'h5A, 1'b1, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    checkOutput("m1 LE held Q", qch(1), 32'hA5);
    checkOutput("m1 LE held CHG", 32'(chg[1]), 32'h0);
    #1 applyStimulus(1, 8'h5A, 1'b0, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    #1 applyStimulus(1, 8'h5A, 1'b1, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    checkOutput("m1 second rise Q", qch(1), 32'h5A);
    checkOutput("m1 second rise CHG", 32'(chg[1]), 32'h1);

    // Output enable leaves stored data untouched
    #1 applyStimulus(2, 8'h3C, 1'b1, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    checkOutput("oe stored Q", qch(2), 32'h3C);
    #1 applyStimulus(2, 8'h3C, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    #1 applyStimulus(2, 8'h3C, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("oe QOE after 1 edge", 32'(qoe[2]), 32'h1);
    @(negedge clk);
    checkOutput("oe QOE off", 32'(qoe[2]), 32'h0);
    checkOutput("oe Q off", qch(2), 32'h0);
    #1 applyStimulus(2, 8'h3C, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    checkOutput("oe Q restored", qch(2), 32'h3C);
    checkOutput("oe CHG quiet", 32'(chg[2]), 32'h0);

    // Switching to edge mode while LE is high must not capture
    #1 applyStimulus(3, 8'h11, 1'b1, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    checkOutput("switch Q 11", qch(3), 32'h11);
    #1 applyStimulus(3, 8'h22, 1'b1, 1'b0, 1'b1);
    repeat (5) @(negedge clk);
    checkOutput("switch no capture Q", qch(3), 32'h11);
    checkOutput("switch no capture CHG", 32'(chg[3]), 32'h0);

    // Mid-operation reset clears outputs at once
    #1 rst_n = 1'b0;
    #1;
    checkOutput("async reset Q", q, 32'h0);
    checkOutput("async reset QOE", 32'(qoe), 32'h0);
    checkOutput("async reset CHG", 32'(chg), 32'h0);
    @(negedge clk); #1 rst_n = 1'b1;
    // ch1 is mode 1 with LE stuck high: exactly one capture after release
    repeat (3) @(negedge clk);
    checkOutput("stuck LE capture Q", qch(1), 32'h5A);
    checkOutput("stuck LE capture CHG", 32'(chg[1]), 32'h1);
    #1 applyStimulus(1, 8'h77, 1'b1, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    checkOutput("stuck LE single capture", qch(1), 32'h5A);

    // Random traffic against the model
    for (int k = 0; k < 1500; k++) begin
      @(negedge clk); #1;
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(0, 1) == 1)
          d[c*W +: W] = ($urandom_range(0, 3) == 0) ? 8'h5A : 8'($urandom);
        if ($urandom_range(0, 9) < 3) le[c] = ~le[c];
        if ($urandom_range(0, 9) == 0) noe[c] = ~noe[c];
        if ($urandom_range(0, 19) == 0) mode[c] = ~mode[c];
      end
    end

    // Narrow bank with deeper synchroniser: 4-edge latency, independent channels
    @(negedge clk); #1;
    d_b  = {4'hA, 4'h5};
    le_b = 2'b11;
    repeat (3) @(negedge clk);
    checkOutput("bank_b Q before 4 edges", 32'(q_b), 32'h00);
    @(negedge clk);
    checkOutput("bank_b Q after 4 edges", 32'(q_b), 32'hA5);
    checkOutput("bank_b CHG", 32'(chg_b), 32'h3);
    #1;
    d_b  = {4'h7, 4'h3};
    le_b = 2'b10;
    repeat (4) @(negedge clk);
    checkOutput("bank_b independent Q", 32'(q_b), 32'h75);
    checkOutput("bank_b independent CHG", 32'(chg_b), 32'h2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
